dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Multi-cycle data-memory responder on the memory-stage side of the pipelined datapath.
//  Consumes ALUOutM (address), WriteDataM and the M-stage request and write strobes.
//  Returns ReadData and raises MemStall to freeze the F/D/E/M pipeline registers until
//  the access completes. Word-addressed storage with a fixed, parameterised wait count.
// PARAMETERS
//  DEPTH_WORDS  64  number of 32-bit words; power of 2, >= 4
//  LATENCY      2   stall cycles per access; 1..15; LATENCY=0 is an elaboration error
//  ADDR_W       6   word-index width; must equal log2(DEPTH_WORDS)
// PORTS
//  clk         in   1   single clock; all state updates on posedge
//  reset       in   1   synchronous, active-high
//  MemReqM     in   1   M-stage instruction is a load or store
//  MemWriteM   in   1   1 = store, 0 = load; meaningful only with MemReqM
//  ALUOutM     in   32  byte address
//  WriteDataM  in   32  store data
//  ReadData    out  32  load data; registered
//  MemStall    out  1   hold pipeline; combinational from state and MemReqM
//  AddrErr     out  1   one-cycle pulse in DONE for a faulting access
// BEHAVIOUR
//  - Reset values: ReadData=0, MemStall=0, AddrErr=0, state=IDLE, counter=0.
//    Reset does not clear the storage array.
//  - Word index = ALUOutM[ADDR_W+1:2].
//  - Fault = ALUOutM[1:0]!=0, or any of ALUOutM[31:ADDR_W+2] nonzero.
//  - FSM states: IDLE, WAIT, DONE.
//  - IDLE:
//    - MemReqM=0: MemStall=0.
//    - MemReqM=1: MemStall=1 in the same cycle. Latch addr, data, write and fault;
//      load cnt=LATENCY-1. Next state: WAIT if LATENCY>1, else DONE.
//  - WAIT:
//    - MemStall=1; cnt decrements each cycle; go to DONE when cnt==1.
//    - Inputs are ignored; all access parameters are taken from the latched copy.
//  - Edge entering DONE:
//    - Store without fault: mem[idx] <= data.
//    - Load without fault: ReadData <= mem[idx].
//    - Faulting load: ReadData <= 0. Faulting store: memory unchanged.
//  - DONE:
//    - MemStall=0; AddrErr=latched fault; ReadData is valid for the M/W register capture.
//    - Next state is always IDLE. MemReqM still high here belongs to the same
//      instruction and must not retrigger.
//  - Timing: a request first seen in IDLE at cycle t stalls cycles t..t+LATENCY-1.
//    DONE occurs at cycle t+LATENCY. The earliest following request is serviced
//    starting at t+LATENCY+1.
//  - ReadData holds its last value outside DONE; stores never modify it.
//  - Reset asserted in WAIT or DONE: return to IDLE and drop the pending access.
//    A store not yet committed is lost. MemStall=0 in the cycle after reset.
//  - MemWriteM while MemReqM=0: no effect.
// TESTING
//  1. Reset, then idle with MemReqM=0 -> MemStall=0, ReadData=0, AddrErr=0 every cycle.
//  2. Store 0xDEADBEEF @0x10, then load @0x10 (LATENCY=2):
//     MemStall high exactly 2 cycles per access; ReadData=0xDEADBEEF in the load's DONE.
//  3. Back-to-back loads @0x0 and @0x4 preloaded with 1 and 2:
//     stall pattern 1,1,0,1,1,0; ReadData 1 then 2; no extra access is triggered in DONE.
//  4. Store @0x12 (misaligned):
//     AddrErr=1 for 1 cycle in DONE; word @0x10 unchanged; stall length still LATENCY.
//     Load @0x400 (DEPTH=64): AddrErr=1, ReadData=0.
//  5. Store 0x55 @0x8; assert reset in the WAIT cycle:
//     MemStall=0 next cycle; a later load @0x8 returns the prior value, not 0x55.
//  6. LATENCY=1 build, load @0x20 = 0x1234:
//     MemStall for 1 cycle; DONE in the next cycle with ReadData=0x1234.

Source files
------------

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : M-stage data-memory bus between the pipeline and the
//               multi-cycle data-memory responder.
//               master : pipeline side (drives request, consumes response)
//               slave  : responder side
//   MemReqM    (m->s) 1   access request (load or store)
//   MemWriteM  (m->s) 1   1 = store, 0 = load
//   ALUOutM    (m->s) 32  byte address
//   WriteDataM (m->s) 32  store data
//   ReadData   (s->m) 32  registered load data
//   MemStall   (s->m) 1   freeze F/D/E/M pipeline registers
//   AddrErr    (s->m) 1   one-cycle fault pulse in DONE
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
  logic        MemReqM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadData;
  logic        MemStall;
  logic        AddrErr;

  modport master (
    output MemReqM, MemWriteM, ALUOutM, WriteDataM,
    input  ReadData, MemStall, AddrErr
  );

  modport slave (
    input  MemReqM, MemWriteM, ALUOutM, WriteDataM,
    output ReadData, MemStall, AddrErr
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Multi-cycle word-addressed data memory for the M stage.
//               A request seen in IDLE stalls the pipeline for LATENCY
//               cycles, then completes in a single DONE cycle in which
//               ReadData is valid and AddrErr flags a faulting access.
// Ports       : clk   - clock, all state on posedge
//               reset - synchronous active-high reset
//               bus   - dmem_responder_if.slave (request/response bus)
// Parameters  : DEPTH_WORDS - number of 32-bit words (power of 2, >= 4)
//               LATENCY     - stall cycles per access (1..15)
//               ADDR_W      - word-index width, log2(DEPTH_WORDS)
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = 6
) (
  input  wire logic        clk,
  input  wire logic        reset,
  dmem_responder_if.slave  bus
);

  // Parameter sanity: reject illegal builds at elaboration.
  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be in 1..15");
    end
    if (ADDR_W != $clog2(DEPTH_WORDS) || DEPTH_WORDS < 4) begin : g_bad_depth
      $error("dmem_responder: ADDR_W must equal log2(DEPTH_WORDS), DEPTH_WORDS >= 4");
    end
  endgenerate

  localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);
  localparam bit         c_SINGLE   = (LATENCY == 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_idx;
  logic [31:0]         r_data;
  logic                r_write;
  logic                r_fault;
  logic [31:0]         r_rdata;
  logic                r_addr_err;
  logic [31:0]         r_mem [DEPTH_WORDS];

  logic                w_in_idle;
  logic                w_req_fault;
  logic [ADDR_W-1:0]   w_req_idx;
  logic [ADDR_W-1:0]   w_acc_idx;
  logic [31:0]         w_acc_data;
  logic                w_acc_write;
  logic                w_acc_fault;
  logic                w_enter_done;
  logic                w_mem_we;

  // Request decode: misaligned or beyond the array is a fault.
  assign w_req_fault = (bus.ALUOutM[1:0] != 2'b00) | (|bus.ALUOutM[31:ADDR_W+2]);
  assign w_req_idx   = bus.ALUOutM[ADDR_W+1:2];
  assign w_in_idle   = (r_state == S_IDLE);

  // With LATENCY=1 the commit edge is the one leaving IDLE, so the access
  // parameters come straight from the bus; otherwise from the latched copy.
  assign w_acc_idx   = w_in_idle ? w_req_idx      : r_idx;
  assign w_acc_data  = w_in_idle ? bus.WriteDataM : r_data;
  assign w_acc_write = w_in_idle ? bus.MemWriteM  : r_write;
  assign w_acc_fault = w_in_idle ? w_req_fault    : r_fault;

  assign w_enter_done = (w_in_idle & bus.MemReqM & c_SINGLE) |
                        ((r_state == S_WAIT) & (r_cnt == 4'd1));

  // Reset on the commit edge drops the pending store.
  assign w_mem_we = w_enter_done & w_acc_write & ~w_acc_fault & ~reset;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_acc_idx] <= w_acc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_idx      <= '0;
      r_data     <= 32'd0;
      r_write    <= 1'b0;
      r_fault    <= 1'b0;
      r_rdata    <= 32'd0;
      r_addr_err <= 1'b0;
    end else begin
      r_addr_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.MemReqM) begin
            r_idx   <= w_req_idx;
            r_data  <= bus.WriteDataM;
            r_write <= bus.MemWriteM;
            r_fault <= w_req_fault;
            r_cnt   <= c_CNT_INIT;
            r_state <= c_SINGLE ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_DONE;
          end
        end
        // MemReqM still high here is the same instruction: never retrigger.
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_enter_done) begin
        r_addr_err <= w_acc_fault;
        if (!w_acc_write) begin
          r_rdata <= w_acc_fault ? 32'd0 : r_mem[w_acc_idx];
        end
      end
    end
  end

  assign bus.MemStall = (r_state == S_WAIT) | (w_in_idle & bus.MemReqM);
  assign bus.ReadData = r_rdata;
  assign bus.AddrErr  = r_addr_err;

endmodule
`default_nettype wire
